// File: rtl/apb_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : apb_reg_slave                                                   |
// | Brief  : APB slave exposing six R/W registers, a transfer counter and ID |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module apb_reg_slave #(
  parameter int                  DATASIZE    = 32,
  parameter int                  ADDRSIZE    = 32,
  parameter int                  WAIT_STATES = 0,
  parameter logic [DATASIZE-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [ADDRSIZE-1:0]     PADDR,
  input  logic                    PWRITE,
  input  logic [DATASIZE-1:0]     PWDATA,
  input  logic [DATASIZE/8-1:0]   PSTRB,
  input  logic [2:0]              PPROT,
  output logic                    pready,
  output logic                    pslverr,
  output logic [DATASIZE-1:0]     prdata
);

  localparam int         c_nbytes = DATASIZE / 8;
  localparam logic [3:0] c_wait   = 4'(WAIT_STATES);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t              r_state;
  logic [3:0]          r_wait_cnt;
  logic [DATASIZE-1:0] r_regs [6];
  logic [DATASIZE-1:0] r_xfer_cnt;

  logic [2:0]          w_idx;
  logic                w_addr_err;
  logic                w_err;
  logic [DATASIZE-1:0] w_rd_val;
  logic                w_unused_bits;

  // Upper address bits and the non-privilege PPROT bits carry no meaning here.
  assign w_unused_bits = ^{PADDR[ADDRSIZE-1:12], PPROT[2:1]};

  always_comb begin
    w_idx      = PADDR[4:2];
    w_addr_err = (PADDR[1:0] != 2'b00) || (PADDR[11:5] != 7'd0);
    w_err      = w_addr_err
              || (PWRITE && (w_idx >= 3'd6))
              || (PWRITE && (w_idx == 3'd0) && !PPROT[0]);
    case (w_idx)
      3'd6:    w_rd_val = r_xfer_cnt;
      3'd7:    w_rd_val = ID_VALUE;
      default: w_rd_val = r_regs[w_idx];
    endcase
  end

  assign pready  = (r_state == S_ACCESS) && (r_wait_cnt == 4'd0);
  assign pslverr = pready && w_err;
  assign prdata  = (pready && !PWRITE && !w_err) ? w_rd_val : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_xfer_cnt <= '0;
      for (int i = 0; i < 6; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (PSEL && !PENABLE) begin
            r_state    <= S_ACCESS;
            r_wait_cnt <= c_wait;
          end
        end
        S_ACCESS: begin
          // Dropping PSEL mid-transfer abandons it with no side effects.
          if (!PSEL) begin
            r_state <= S_IDLE;
          end else if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end else if (PENABLE) begin
            r_state <= S_IDLE;
            if (!w_err) begin
              r_xfer_cnt <= r_xfer_cnt + DATASIZE'(1);
              if (PWRITE && (w_idx < 3'd6)) begin
                for (int b = 0; b < c_nbytes; b++) begin
                  if (PSTRB[b]) r_regs[w_idx][8*b +: 8] <= PWDATA[8*b +: 8];
                end
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_apb_reg_slave                                                |
// | Brief  : Self-checking bench for apb_reg_slave (0 and 3 wait states)     |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_apb_reg_slave;

  localparam logic [31:0] c_id  = 32'hA9B0_0001;
  localparam int          c_ws1 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready  [2];
  logic        pslverr [2];
  logic [31:0] prdata  [2];

  always #5 clk = ~clk;

  apb_reg_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .PSEL(psel[0]), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .pready(pready[0]), .pslverr(pslverr[0]), .prdata(prdata[0])
  );

  apb_reg_slave #(.WAIT_STATES(c_ws1)) dut1 (
    .clk(clk), .reset(reset), .PSEL(psel[1]), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .pready(pready[1]), .pslverr(pslverr[1]), .prdata(prdata[1])
  );

  // Reference state: register contents and completed-transfer count per slave.
  logic [31:0] m_regs [2][6];
  logic [31:0] m_cnt  [2];
  logic        exp_pready [2];
  logic        exp_err    [2];
  logic [31:0] exp_rdata  [2];
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic m_err(input logic [31:0] a, input logic w, input logic [2:0] p);
    int idx;
    idx = int'(a[4:2]);
    return (a[1:0] != 2'b00) || (a[11:5] != 7'd0) || (w && idx >= 6) || (w && idx == 0 && !p[0]);
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [31:0] a);
    int idx;
    idx = int'(a[4:2]);
    if (m_err(a, 1'b0, 3'b001)) return 32'h0;
    if (idx < 6) return m_regs[d][idx];
    if (idx == 6) return m_cnt[d];
    return c_id;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 32'h0;
      for (int r = 0; r < 6; r++) m_regs[d][r] = 32'h0;
    end
  endtask

  task automatic set_exp_idle();
    for (int d = 0; d < 2; d++) begin
      exp_pready[d] = 1'b0;
      exp_err[d]    = 1'b0;
      exp_rdata[d]  = 32'h0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("pready[%0d]", d),  32'(pready[d]),  32'(exp_pready[d]));
        check($sformatf("pslverr[%0d]", d), 32'(pslverr[d]), 32'(exp_err[d]));
        check($sformatf("prdata[%0d]", d),  prdata[d],       exp_rdata[d]);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the transfer ends.
  // abort_k>0 ends the transfer in access cycle abort_k (kind 0: PSEL drop, 1: reset).
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input int abort_k, input int kind,
                      output logic [31:0] got_rd, output logic got_err, output int nacc);
    logic e;
    int   idx, wsd;
    wsd = (d == 0) ? 0 : c_ws1;
    e = m_err(a, w, pr);
    idx = int'(a[4:2]);
    got_rd = 'x; got_err = 1'bx; nacc = 0;
    psel = 2'b00; psel[d] = 1'b1; penable = 1'b0;
    paddr = a; pwrite = w; pwdata = wd; pstrb = st; pprot = pr;
    set_exp_idle();
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      nacc = k;
      penable = 1'b1;
      set_exp_idle();
      if (k == abort_k) begin
        if (kind == 0) begin psel = 2'b00; penable = 1'b0; end
        else reset = 1'b1;
        @(posedge clk);
        if (kind == 1) clear_model();
        #1;
        reset = 1'b0; psel = 2'b00; penable = 1'b0;
        return;
      end
      if (k > wsd) begin
        exp_pready[d] = 1'b1;
        exp_err[d]    = e;
        exp_rdata[d]  = w ? 32'h0 : m_read(d, a);
        @(negedge clk);
        got_rd = prdata[d];
        got_err = pslverr[d];
        @(posedge clk);
        if (!e) begin
          if (w && idx < 6)
            for (int b = 0; b < 4; b++) if (st[b]) m_regs[d][idx][8*b +: 8] = wd[8*b +: 8];
          m_cnt[d] = m_cnt[d] + 32'd1;
        end
        #1;
        set_exp_idle();
        return;
      end
    end
  endtask

  // Idle cycles; viol=1 presents PSEL with PENABLE already high, which must be ignored.
  task automatic idle(input int n, input bit viol);
    for (int i = 0; i < n; i++) begin
      psel = 2'b00; penable = 1'b0;
      if (viol) begin psel[$urandom_range(0, 1)] = 1'b1; penable = 1'b1; end
      set_exp_idle();
      @(posedge clk); #1;
    end
    psel = 2'b00; penable = 1'b0;
  endtask

  logic [31:0] rd, a;
  logic        er;
  int          n, d, sel, idx, ab;

  initial begin
    reset = 1'b1; psel = 2'b00; penable = 1'b0; paddr = 32'h0; pwrite = 1'b0;
    pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b000;
    clear_model();
    set_exp_idle();
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_pready0", 32'(pready[0]), 32'h0);
    check("rst_pslverr1", 32'(pslverr[1]), 32'h0);
    check("rst_prdata0", prdata[0], 32'h0);
    @(posedge clk); #1;

    // Zero-wait write then read
    xfer(0, 32'h004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001, 0, 0, rd, er, n);
    check("zw_wr_latency", n, 1);
    check("zw_wr_err", 32'(er), 32'h0);
    xfer(0, 32'h004, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("zw_rd_latency", n, 1);
    check("zw_rd_data", rd, 32'hDEAD_BEEF);
    xfer(0, 32'h018, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("zw_r6", rd, 32'd2);

    // Three wait states on the ID register
    idle(1, 1'b0);
    xfer(1, 32'h01C, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("ws3_latency", n, 4);
    check("ws3_id", rd, 32'hA9B0_0001);

    // Partial and empty strobes
    xfer(0, 32'h004, 1'b1, 32'h1122_3344, 4'hF, 3'b001, 0, 0, rd, er, n);
    xfer(0, 32'h004, 1'b1, 32'hFFFF_FFFF, 4'b0101, 3'b001, 0, 0, rd, er, n);
    xfer(0, 32'h004, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("strb_0101", rd, 32'h11FF_33FF);
    xfer(0, 32'h004, 1'b1, 32'h0, 4'h0, 3'b001, 0, 0, rd, er, n);
    check("strb_none_err", 32'(er), 32'h0);
    xfer(0, 32'h004, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("strb_none_keep", rd, 32'h11FF_33FF);

    // Error responses
    xfer(0, 32'h000, 1'b1, 32'h5A5A_5A5A, 4'hF, 3'b001, 0, 0, rd, er, n);
    xfer(0, 32'h018, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("cnt_before_err", rd, 32'd9);
    xfer(0, 32'h018, 1'b1, 32'h1234_0000, 4'hF, 3'b001, 0, 0, rd, er, n);
    check("err_wr_r6", 32'(er), 32'h1);
    xfer(0, 32'h020, 1'b0, 32'h0, 4'h0, 3'b001, 0, 0, rd, er, n);
    check("err_rd_oor", 32'(er), 32'h1);
    check("err_rd_oor_data", rd, 32'h0);
    xfer(0, 32'h000, 1'b1, 32'h0BAD_0BAD, 4'hF, 3'b000, 0, 0, rd, er, n);
    check("err_unpriv_r0", 32'(er), 32'h1);
    xfer(0, 32'h000, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("r0_unchanged", rd, 32'h5A5A_5A5A);
    xfer(0, 32'h018, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("cnt_after_err", rd, 32'd11);

    // Abort mid-wait, then reset inside ACCESS
    xfer(1, 32'h008, 1'b1, 32'h1234_5678, 4'hF, 3'b001, 2, 0, rd, er, n);
    xfer(1, 32'h008, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("abort_no_write", rd, 32'h0);
    xfer(1, 32'h00C, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b001, 0, 0, rd, er, n);
    xfer(1, 32'h010, 1'b1, 32'h7777_7777, 4'hF, 3'b001, 1, 1, rd, er, n);
    @(negedge clk);
    check("rst_access_idle", 32'(pready[1]), 32'h0);
    @(posedge clk); #1;
    xfer(1, 32'h00C, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("rst_r3_cleared", rd, 32'h0);
    check("rst_new_xfer_latency", n, 4);
    xfer(0, 32'h004, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("rst_r1_cleared", rd, 32'h0);

    // Transfer counter wrap
    force dut0.r_xfer_cnt = 32'hFFFF_FFFF;
    idle(1, 1'b0);
    release dut0.r_xfer_cnt;
    m_cnt[0] = 32'hFFFF_FFFF;
    xfer(0, 32'h018, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("wrap_pre", rd, 32'hFFFF_FFFF);
    xfer(0, 32'h018, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, n);
    check("wrap_post", rd, 32'h0);

    // Randomized traffic against the reference model
    for (int it = 0; it < 250; it++) begin
      d   = $urandom_range(0, 1);
      idx = $urandom_range(0, 7);
      sel = $urandom_range(0, 9);
      a   = 32'(idx) << 2;
      if (sel == 7) a = a | 32'($urandom_range(1, 3));
      else if (sel == 8) a = a | (32'($urandom_range(1, 127)) << 5);
      else if (sel == 9) a = a | ($urandom & 32'hFFFF_F000);
      ab = (d == 1 && $urandom_range(0, 7) == 0) ? $urandom_range(1, c_ws1) : 0;
      xfer(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), ab, 0, rd, er, n);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    idle(2, 1'b0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter DATASIZE, 32, data width for PWDATA and prdata.
REQ-002 SHALL have parameter ADDRSIZE, 32, width of PADDR.
REQ-003 SHALL have parameter WAIT_STATES, 0, number of wait states inserted in each access phase (0..15).
REQ-004 SHALL have parameter ID_VALUE, 32'hA9B0_0001, read-only value of register 7.
REQ-005 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port PSEL, input, 1, select from the bridge's decoded PSELn.
REQ-008 SHALL have port PENABLE, input, 1, access-phase indicator.
REQ-009 SHALL have port PADDR, input, ADDRSIZE, byte address; only bits [11:0] are decoded.
REQ-010 SHALL have port PWRITE, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port PWDATA, input, DATASIZE, write data.
REQ-012 SHALL have port PSTRB, input, DATASIZE/8, byte-lane write strobes.
REQ-013 SHALL have port PPROT, input, 3, protection attributes; bit 0 = privileged.
REQ-014 SHALL have port pready, output, 1, transfer completion.
REQ-015 SHALL have port pslverr, output, 1, error response, valid only while pready=1.
REQ-016 SHALL have port prdata, output, DATASIZE, read data, valid only while pready=1 on reads.

Function
REQ-017 SHALL implement an FSM with states IDLE and ACCESS.
- IDLE->ACCESS when PSEL=1 and PENABLE=0 (setup phase); wait counter loaded with WAIT_STATES.
- ACCESS->IDLE on the edge where PSEL=1, PENABLE=1 and pready=1.
REQ-018 SHALL decrement the wait counter by 1 per ACCESS cycle while it is nonzero.
REQ-019 SHALL drive pready=1 combinationally only in state ACCESS with counter=0; otherwise pready=0.
- Zero-wait transfer: 1 setup cycle + 1 access cycle.
- WAIT_STATES=N: pready rises in access cycle N+1.
REQ-020 SHALL decode register index = PADDR[4:2] and hold 8 registers: R0-R5 read/write, R6 transfer counter (read-only), R7 ID_VALUE (read-only).
REQ-021 SHALL flag an error if PADDR[1:0]!=0 or PADDR[11:5]!=0; a flagged read returns prdata=0.
REQ-022 SHALL flag an error on a write to R6 or R7.
REQ-023 SHALL flag an error on a write to R0 with PPROT[0]=0; reads of R0 are unrestricted.
REQ-024 SHALL drive pslverr=1 on the completing (pready=1) cycle of a flagged transfer, and pslverr=0 at all other times.
REQ-025 SHALL commit writes only on the completing edge and only when no error is flagged.
- Byte lane i is updated only if PSTRB[i]=1.
- PSTRB=0 completes without error and leaves the register unchanged.
REQ-026 SHALL drive prdata combinationally from the selected register during the completing read cycle, and 0 otherwise.
REQ-027 SHALL increment R6 by 1 (mod 2^32, wrapping FFFF_FFFF->0) on each completing non-error transfer, read or write.
- A read of R6 returns the pre-increment value.
REQ-028 SHALL abort to IDLE without a write or counter update if PSEL drops while in ACCESS.
REQ-029 SHALL ignore PENABLE=1 seen in IDLE (protocol violation); the FSM remains in IDLE.
REQ-030 SHALL sample PADDR, PWRITE, PWDATA, PSTRB and PPROT on the completing edge (APB holds them stable across the transfer).
REQ-031 SHALL accept back-to-back transfers: a new setup phase immediately after completion is taken from IDLE.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, set the FSM to IDLE, the wait counter to 0, R0-R6 to 0, pready=0, pslverr=0 and prdata=0.
REQ-033 SHALL give reset priority over any in-flight transfer; an access in progress is dropped and no write is committed.

Verification
REQ-034 Zero-wait write then read: write 32'hDEAD_BEEF to 0x004 with PSTRB=F, then read 0x004 -> pready on the 2nd cycle of each transfer, prdata=DEAD_BEEF, pslverr=0, R6=2.
REQ-035 WAIT_STATES=3: read 0x01C -> pready=0 for 3 access cycles, then 1 with prdata=A9B0_0001.
REQ-036 Partial strobe: R1=1122_3344, then write FFFF_FFFF with PSTRB=4'b0101 -> R1 reads 11FF_33FF.
REQ-037 Errors, each giving pslverr=1 with the target register unchanged and R6 not incremented:
- write to 0x018;
- read of 0x020 (prdata=0);
- write to 0x000 with PPROT=3'b000.
REQ-038 Abort and reset: PSEL dropped mid-wait -> no write; reset asserted in ACCESS -> next cycle IDLE, all registers 0.
REQ-039 R6 wrap: preload R6 to FFFF_FFFF via force, then one good transfer -> R6=0.
